// File: rtl/arbiter_pkg.sv
// Shared encodings and sizing helper for the arbiter and its encoders.
package arbiter_pkg;

    typedef enum logic {
        ARB_FIXED       = 1'b0,
        ARB_ROUND_ROBIN = 1'b1
    } arb_type_e;

    typedef enum logic {
        REL_REQ_DROP = 1'b0,
        REL_ACK      = 1'b1
    } arb_release_e;

    // Index width, never below one bit so a 1-port encoder still has a port.
    function automatic int idx_width(input int ports);
        return ($clog2(ports) > 1) ? $clog2(ports) : 1;
    endfunction

endpackage

// File: rtl/arbiter_priority_encoder.sv
// Combinational priority encoder: picks one set bit of the input vector,
// lowest index wins when LSB_HIGH_PRIORITY=1, highest index otherwise.
module priority_encoder
    import arbiter_pkg::*;
#(
    parameter int WIDTH             = 4,
    parameter bit LSB_HIGH_PRIORITY = 1'b0
) (
    input  logic [WIDTH-1:0]            input_unencoded,
    output logic                        output_valid,
    output logic [idx_width(WIDTH)-1:0] output_encoded,
    output logic [WIDTH-1:0]            output_unencoded
);

    localparam int W = idx_width(WIDTH);

    // Scan so that the preferred bit is the last one written.
    always_comb begin
        output_valid     = |input_unencoded;
        output_encoded   = '0;
        output_unencoded = '0;
        if (LSB_HIGH_PRIORITY) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (input_unencoded[i]) output_encoded = W'(i);
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (input_unencoded[i]) output_encoded = W'(i);
            end
        end
        if (output_valid) output_unencoded[output_encoded] = 1'b1;
    end

endmodule

// File: rtl/arbiter.sv
// Registered N-port arbiter: fixed priority or round-robin, with optional
// grant hold released either by request drop or by an acknowledge strobe.
module arbiter
    import arbiter_pkg::*;
#(
    parameter int PORTS                 = 4,
    parameter bit ARB_TYPE_ROUND_ROBIN  = 1'b0,
    parameter bit ARB_BLOCK             = 1'b0,
    parameter bit ARB_BLOCK_ACK         = 1'b1,
    parameter bit ARB_LSB_HIGH_PRIORITY = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [PORTS-1:0]           request,
    input  logic [PORTS-1:0]           acknowledge,
    output logic [PORTS-1:0]           grant,
    output logic                       grant_valid,
    output logic [$clog2(PORTS)-1:0]   grant_encoded
);

    localparam int           W     = idx_width(PORTS);
    localparam arb_type_e    L_TYP = arb_type_e'(ARB_TYPE_ROUND_ROBIN);
    localparam arb_release_e L_REL = arb_release_e'(ARB_BLOCK_ACK);

    logic [PORTS-1:0] r_grant;
    logic             r_grant_valid;
    logic [W-1:0]     r_grant_encoded;
    logic [PORTS-1:0] r_mask;

    logic             w_req_valid;
    logic [W-1:0]     w_req_enc;
    logic [PORTS-1:0] w_req_oh;
    logic             w_msk_valid;
    logic [W-1:0]     w_msk_enc;
    logic [PORTS-1:0] w_msk_oh;
    logic [PORTS-1:0] w_req_masked;

    logic             w_hold;
    logic [PORTS-1:0] w_grant_nxt;
    logic             w_valid_nxt;
    logic [W-1:0]     w_enc_nxt;
    logic [PORTS-1:0] w_mask_nxt;

    assign w_req_masked = request & r_mask;

    priority_encoder #(
        .WIDTH             (PORTS),
        .LSB_HIGH_PRIORITY (ARB_LSB_HIGH_PRIORITY)
    ) u_pe_req (
        .input_unencoded  (request),
        .output_valid     (w_req_valid),
        .output_encoded   (w_req_enc),
        .output_unencoded (w_req_oh)
    );

    priority_encoder #(
        .WIDTH             (PORTS),
        .LSB_HIGH_PRIORITY (ARB_LSB_HIGH_PRIORITY)
    ) u_pe_msk (
        .input_unencoded  (w_req_masked),
        .output_valid     (w_msk_valid),
        .output_encoded   (w_msk_enc),
        .output_unencoded (w_msk_oh)
    );

    // Hold decision, then next grant and next round-robin mask.
    always_comb begin
        w_hold      = 1'b0;
        w_grant_nxt = r_grant;
        w_valid_nxt = r_grant_valid;
        w_enc_nxt   = r_grant_encoded;
        w_mask_nxt  = r_mask;

        if (ARB_BLOCK) begin
            if (L_REL == REL_ACK)
                w_hold = r_grant_valid && ((acknowledge & r_grant) == '0);
            else
                w_hold = |(request & r_grant);
        end

        if (!w_hold) begin
            if (L_TYP == ARB_ROUND_ROBIN && w_msk_valid) begin
                w_grant_nxt = w_msk_oh;
                w_valid_nxt = 1'b1;
                w_enc_nxt   = w_msk_enc;
            end else if (w_req_valid) begin
                w_grant_nxt = w_req_oh;
                w_valid_nxt = 1'b1;
                w_enc_nxt   = w_req_enc;
            end else begin
                w_grant_nxt = '0;
                w_valid_nxt = 1'b0;
                w_enc_nxt   = '0;
            end
            // Mask the winner and everything of higher priority; a winner at
            // the lowest-priority edge leaves an empty mask, so the next
            // round starts from the unmasked path.
            if (L_TYP == ARB_ROUND_ROBIN && w_valid_nxt) begin
                for (int j = 0; j < PORTS; j++) begin
                    w_mask_nxt[j] = ARB_LSB_HIGH_PRIORITY ? (j > int'(w_enc_nxt))
                                                          : (j < int'(w_enc_nxt));
                end
            end
        end
    end

    // Grant and mask state; reset clears everything without waiting on clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant         <= '0;
            r_grant_valid   <= 1'b0;
            r_grant_encoded <= '0;
            r_mask          <= '0;
        end else begin
            r_grant         <= w_grant_nxt;
            r_grant_valid   <= w_valid_nxt;
            r_grant_encoded <= w_enc_nxt;
            r_mask          <= w_mask_nxt;
        end
    end

    assign grant         = r_grant;
    assign grant_valid   = r_grant_valid;
    assign grant_encoded = r_grant_encoded;

endmodule

// File: tb/tb_arbiter.sv
// Directed bench for arbiter: fixed/round-robin, hold modes, async reset.
module tb_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] no_ack = '0;
    logic [3:0] req_fix = '0, req_rr = '0, req_ack = '0, ack_ack = '0, req_nak = '0;

    logic [3:0] g_fix, g_msb, g_rr, g_ack, g_nak;
    logic       v_fix, v_msb, v_rr, v_ack, v_nak;
    logic [1:0] e_fix, e_msb, e_rr, e_ack, e_nak;

    int n_checks = 0;
    int n_errors = 0;

    // fixed, LSB high, no hold
    arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(1'b0), .ARB_BLOCK(1'b0),
              .ARB_BLOCK_ACK(1'b1), .ARB_LSB_HIGH_PRIORITY(1'b1)) u_fix (
        .clk(clk), .rst_n(rst_n), .request(req_fix), .acknowledge(no_ack),
        .grant(g_fix), .grant_valid(v_fix), .grant_encoded(e_fix));

    // defaults: fixed, MSB high, no hold
    arbiter #(.PORTS(4)) u_msb (
        .clk(clk), .rst_n(rst_n), .request(req_fix), .acknowledge(no_ack),
        .grant(g_msb), .grant_valid(v_msb), .grant_encoded(e_msb));

    // round-robin, LSB high, no hold
    arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(1'b1), .ARB_BLOCK(1'b0),
              .ARB_BLOCK_ACK(1'b1), .ARB_LSB_HIGH_PRIORITY(1'b1)) u_rr (
        .clk(clk), .rst_n(rst_n), .request(req_rr), .acknowledge(no_ack),
        .grant(g_rr), .grant_valid(v_rr), .grant_encoded(e_rr));

    // fixed, LSB high, hold until acknowledge
    arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(1'b0), .ARB_BLOCK(1'b1),
              .ARB_BLOCK_ACK(1'b1), .ARB_LSB_HIGH_PRIORITY(1'b1)) u_ack (
        .clk(clk), .rst_n(rst_n), .request(req_ack), .acknowledge(ack_ack),
        .grant(g_ack), .grant_valid(v_ack), .grant_encoded(e_ack));

    // fixed, LSB high, hold until request drop
    arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(1'b0), .ARB_BLOCK(1'b1),
              .ARB_BLOCK_ACK(1'b0), .ARB_LSB_HIGH_PRIORITY(1'b1)) u_nak (
        .clk(clk), .rst_n(rst_n), .request(req_nak), .acknowledge(no_ack),
        .grant(g_nak), .grant_valid(v_nak), .grant_encoded(e_nak));

    typedef struct {
        logic [3:0] req;
        logic [3:0] g_lsb;
        logic [1:0] e_lsb;
        logic [3:0] g_msb;
        logic [1:0] e_msb;
    } vec_t;

    typedef struct {
        logic [3:0] req;
        logic [3:0] g;
        logic [1:0] e;
    } rr_t;

    vec_t vecs[7];
    rr_t  rrv[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // grant, grant_valid and grant_encoded together
    task automatic check_out(input string name, input logic [3:0] g, input logic v,
                             input logic [1:0] e, input logic [3:0] eg, input logic [1:0] ee);
        check({name, ".grant"}, 32'(g), 32'(eg));
        check({name, ".valid"}, 32'(v), 32'(eg != 4'b0000));
        check({name, ".enc"},   32'(e), 32'(ee));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{4'b1010, 4'b0010, 2'd1, 4'b1000, 2'd3};
        vecs[1] = '{4'b0000, 4'b0000, 2'd0, 4'b0000, 2'd0};
        vecs[2] = '{4'b0001, 4'b0001, 2'd0, 4'b0001, 2'd0};
        vecs[3] = '{4'b1111, 4'b0001, 2'd0, 4'b1000, 2'd3};
        vecs[4] = '{4'b0110, 4'b0010, 2'd1, 4'b0100, 2'd2};
        vecs[5] = '{4'b1000, 4'b1000, 2'd3, 4'b1000, 2'd3};
        vecs[6] = '{4'b0101, 4'b0001, 2'd0, 4'b0100, 2'd2};

        rrv[0]  = '{4'b1111, 4'b0001, 2'd0};
        rrv[1]  = '{4'b1111, 4'b0010, 2'd1};
        rrv[2]  = '{4'b1111, 4'b0100, 2'd2};
        rrv[3]  = '{4'b1111, 4'b1000, 2'd3};
        rrv[4]  = '{4'b1111, 4'b0001, 2'd0};
        rrv[5]  = '{4'b0101, 4'b0100, 2'd2};   // masked path
        rrv[6]  = '{4'b0000, 4'b0000, 2'd0};   // idle, mask kept at 1000
        rrv[7]  = '{4'b1001, 4'b1000, 2'd3};   // kept mask picks port 3
        rrv[8]  = '{4'b1111, 4'b0001, 2'd0};   // wrapped to unmasked path
        rrv[9]  = '{4'b1111, 4'b0010, 2'd1};
        rrv[10] = '{4'b1111, 4'b0100, 2'd2};

        // reset state
        #12;
        check_out("rst_fix", g_fix, v_fix, e_fix, 4'b0000, 2'd0);
        check_out("rst_rr",  g_rr,  v_rr,  e_rr,  4'b0000, 2'd0);
        check_out("rst_ack", g_ack, v_ack, e_ack, 4'b0000, 2'd0);
        #1 rst_n = 1'b1;

        // fixed priority, both priority directions
        for (int i = 0; i < 7; i++) begin
            req_fix = vecs[i].req;
            tick();
            check_out($sformatf("fix_lsb[%0d]", i), g_fix, v_fix, e_fix, vecs[i].g_lsb, vecs[i].e_lsb);
            check_out($sformatf("fix_msb[%0d]", i), g_msb, v_msb, e_msb, vecs[i].g_msb, vecs[i].e_msb);
        end
        req_fix = '0;

        // hold until acknowledge
        req_ack = 4'b0110; tick();
        check_out("ack_first", g_ack, v_ack, e_ack, 4'b0010, 2'd1);
        req_ack = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_out($sformatf("ack_hold[%0d]", k), g_ack, v_ack, e_ack, 4'b0010, 2'd1);
        end
        ack_ack = 4'b0001; tick();
        check_out("ack_other", g_ack, v_ack, e_ack, 4'b0010, 2'd1);
        ack_ack = 4'b0010; tick();
        check_out("ack_rearb", g_ack, v_ack, e_ack, 4'b0100, 2'd2);
        ack_ack = 4'b0001; tick();
        check_out("ack_ign2", g_ack, v_ack, e_ack, 4'b0100, 2'd2);
        ack_ack = 4'b0000; req_ack = 4'b0000; tick();
        check_out("ack_noreq", g_ack, v_ack, e_ack, 4'b0100, 2'd2);
        ack_ack = 4'b0100; tick();
        check_out("ack_idle", g_ack, v_ack, e_ack, 4'b0000, 2'd0);
        ack_ack = 4'b0000;

        // hold until request drop; 1001 must not steal the grant from port 3
        req_nak = 4'b1000; tick();
        check_out("nak0", g_nak, v_nak, e_nak, 4'b1000, 2'd3);
        tick();
        check_out("nak1", g_nak, v_nak, e_nak, 4'b1000, 2'd3);
        req_nak = 4'b1001; tick();
        check_out("nak2", g_nak, v_nak, e_nak, 4'b1000, 2'd3);
        req_nak = 4'b0001; tick();
        check_out("nak_switch", g_nak, v_nak, e_nak, 4'b0001, 2'd0);
        req_nak = 4'b0000; tick();
        check_out("nak_idle", g_nak, v_nak, e_nak, 4'b0000, 2'd0);

        // round-robin rotation, masked path, idle, wrap
        for (int i = 0; i < 11; i++) begin
            req_rr = rrv[i].req;
            tick();
            check_out($sformatf("rr[%0d]", i), g_rr, v_rr, e_rr, rrv[i].g, rrv[i].e);
        end

        // async reset between edges while port 2 is granted
        #2 rst_n = 1'b0;
        #1;
        check_out("rst_async", g_rr, v_rr, e_rr, 4'b0000, 2'd0);
        req_rr = 4'b1100;
        #1 rst_n = 1'b1;
        tick();
        check_out("rr_post_rst", g_rr, v_rr, e_rr, 4'b0100, 2'd2);
        req_rr = 4'b0000;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/arbiter.md
ARBITER -- requirements
Module: arbiter

Interface
REQ-001 The block SHALL have parameter PORTS, default 4, giving the number of requesters (legal 2..64).
REQ-002 The block SHALL have parameter ARB_TYPE_ROUND_ROBIN, default 0: 0 = fixed priority, 1 = round-robin.
REQ-003 The block SHALL have parameter ARB_BLOCK, default 0: 1 = hold the grant until it is released.
REQ-004 The block SHALL have parameter ARB_BLOCK_ACK, default 1: when ARB_BLOCK=1, 1 = release on acknowledge, 0 = release on request drop.
REQ-005 The block SHALL have parameter ARB_LSB_HIGH_PRIORITY, default 0: 1 = port 0 highest priority, 0 = port PORTS-1 highest.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-007 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-008 The block SHALL have port request, input, PORTS bits: per-port request level.
REQ-009 The block SHALL have port acknowledge, input, PORTS bits: per-port release strobe, used only when ARB_BLOCK=1 and ARB_BLOCK_ACK=1.
REQ-010 The block SHALL have port grant, output, PORTS bits: one-hot registered grant.
REQ-011 The block SHALL have port grant_valid, output, 1 bit: a grant is currently held.
REQ-012 The block SHALL have port grant_encoded, output, $clog2(PORTS) bits: binary index of the granted port.

Function
REQ-013 All outputs SHALL be registered, and a new grant SHALL appear on the cycle after the request is sampled (latency 1).
REQ-014 grant SHALL be all-zero or exactly one-hot; grant_valid SHALL equal |grant; grant_encoded SHALL be the index of the set grant bit, and 0 when grant_valid=0.
REQ-015 Hold, ARB_BLOCK=1 and ARB_BLOCK_ACK=0: while request & grant is nonzero, the grant SHALL be kept unchanged.
REQ-016 Hold, ARB_BLOCK=1 and ARB_BLOCK_ACK=1: while grant_valid=1 and acknowledge & grant is zero, the grant SHALL be kept, regardless of request.
REQ-017 Release with ARB_BLOCK_ACK=1: an acknowledge on the granted port SHALL free the arbiter, and in the same cycle it SHALL re-arbitrate over the current request, so back-to-back grants occur with no idle cycle.
REQ-018 With ARB_BLOCK=0, the block SHALL re-arbitrate every cycle.
REQ-019 Fixed priority: when not holding and request is nonzero, the block SHALL grant the highest-priority requesting port per ARB_LSB_HIGH_PRIORITY.
REQ-020 Round-robin: the block SHALL keep a PORTS-bit mask register.
REQ-021 Round-robin: if request & mask is nonzero, the block SHALL grant the highest-priority bit of request & mask; otherwise it SHALL grant the highest-priority bit of request.
REQ-022 Mask update on each new grant of index i: with ARB_LSB_HIGH_PRIORITY=1 the mask SHALL become the bits strictly above i; with ARB_LSB_HIGH_PRIORITY=0 it SHALL become the bits strictly below i.
REQ-023 Wrap-around: when i is at the mask edge, the mask becomes all-zero and the next grant SHALL come from the unmasked path.
REQ-024 When not holding and request is all-zero, grant, grant_valid and grant_encoded SHALL go to 0 and the mask SHALL be unchanged.
REQ-025 An acknowledge on a non-granted port SHALL be ignored.
REQ-026 When a held request drops in ack mode, the grant SHALL stay until acknowledged.

Reset
REQ-027 rst_n low SHALL asynchronously force grant=0, grant_valid=0, grant_encoded=0 and mask=0.
REQ-028 After rst_n is deasserted, the first arbitration SHALL use the unmasked path.
REQ-029 Reset mid-hold SHALL drop the grant immediately, without waiting for the next clock edge.

Structure
REQ-030 The shared package SHALL hold the arbitration-type and release-mode encodings and a function computing index width as max($clog2(PORTS),1).
REQ-031 The block SHALL instantiate the existing priority_encoder twice (request, and request & mask), with WIDTH=PORTS and LSB_HIGH_PRIORITY=ARB_LSB_HIGH_PRIORITY.
REQ-032 The block SHALL contain no other sub-modules.

Verification
REQ-033 Scenario: PORTS=4, fixed, LSB-high, ARB_BLOCK=0, request=4'b1010 -> next cycle grant=4'b0010, grant_encoded=1, grant_valid=1.
REQ-034 Scenario: round-robin, LSB-high, ARB_BLOCK=0, request held at 4'b1111 for 5 cycles -> grant_encoded sequence 0,1,2,3,0.
REQ-035 Scenario: ARB_BLOCK=1, ARB_BLOCK_ACK=1, request=4'b0110 with port 1 granted; port 1 request drops and no acknowledge for 3 cycles -> grant stays 4'b0010; acknowledge=4'b0010 -> next cycle grant=4'b0100.
REQ-036 Scenario: ARB_BLOCK=1, ARB_BLOCK_ACK=0, request=4'b1000 for 3 cycles then 4'b0001 -> grant 4'b1000 for 3 cycles, then 4'b0001 with no gap cycle.
REQ-037 Scenario: rst_n pulsed low between clock edges while grant=4'b0100 -> outputs 0 immediately; after release with request=4'b1100 in round-robin -> grant_encoded=2.
REQ-038 Scenario: acknowledge=4'b0001 while port 2 is granted in ack mode -> grant unchanged.
